// File: rtl/lm75a_i2c_slave.sv
// LM75A-style I2C register responder: Temp (read-only shadow), Conf, Thyst, Tos.
// SCL/SDA are oversampled on clk; SDA is open-drain (driven low or released).
// Optional macro LM75A_WRITE_EN: when defined, Conf/Thyst/Tos accept writes;
// when undefined, the registers stay at their reset values and data bytes are NACKed.
`timescale 1ns/1ps
module lm75a_i2c_slave #(
  parameter logic [3:0]  ADDR_HI   = 4'b1001,
  parameter logic [15:0] THYST_RST = 16'h4B00,
  parameter logic [15:0] TOS_RST   = 16'h5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [2:0]  i_address,
  input  logic [10:0] temp_in,
  output logic        busy,
  output logic        rd_done,
  output logic [1:0]  pointer_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t      state;
  logic [2:0]  scl_sync;     // [0] first flop, [1] synchronized, [2] previous
  logic [2:0]  sda_sync;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;        // receive shift register
  logic [6:0]  tx;           // remaining bits of the byte being sent
  logic        sda_oe;       // 1 = pull sda low
  logic        rw;
  logic        byte_idx;     // 0 = MSB byte, 1 = LSB byte of a 16-bit register
  logic [15:0] temp_shadow;
  logic [7:0]  conf;
  logic [15:0] thyst;
  logic [15:0] tos;
  logic [15:0] reg16;        // register selected by the pointer
`ifdef LM75A_WRITE_EN
  logic        wr_idx;       // next written byte of a 16-bit register is the LSB
`endif

  logic scl_s, scl_q, sda_s, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Open-drain pad: only ever pull low or float.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_s = scl_sync[1];
  assign scl_q = scl_sync[2];
  assign sda_s = sda_sync[1];
  assign sda_q = sda_sync[2];

  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

  // Two-flop synchronizers plus one history flop for edge detection; idle bus is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old values, giving a true shift chain.
      scl_sync <= {scl_sync[1:0], scl};
      sda_sync <= {sda_sync[1:0], sda};
    end
  end

  // Pointer-selected source; Conf is replicated so every byte served is the same.
  always_comb begin
    // NOTE: default assignment first so no path leaves reg16 unassigned (which would infer a latch).
    reg16 = tos;
    case (pointer_o)
      2'd0:    reg16 = temp_shadow;
      2'd1:    reg16 = {conf, conf};
      2'd2:    reg16 = thyst;
      default: reg16 = tos;
    endcase
  end

  // Protocol FSM with registered sda drive, busy, rd_done and register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      tx          <= 7'h00;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      rd_done     <= 1'b0;
      pointer_o   <= 2'b00;
      rw          <= 1'b0;
      byte_idx    <= 1'b0;
      temp_shadow <= 16'h0000;
      conf        <= 8'h00;
      thyst       <= THYST_RST;
      tos         <= TOS_RST;
`ifdef LM75A_WRITE_EN
      wr_idx      <= 1'b0;
`endif
    end else begin
      rd_done <= 1'b0;
      // Bus conditions override everything, including a coincident scl edge.
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;

          ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shift[7:1] == {ADDR_HI, i_address}) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
                // One snapshot per read so MSB and LSB always belong together.
                if (shift[0]) temp_shadow <= {temp_in, 5'b00000};
              end else begin
                state <= IDLE;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state    <= RDATA;
                byte_idx <= 1'b0;
                tx       <= reg16[14:8];
                sda_oe   <= ~reg16[15];
                bit_cnt  <= 4'd1;
              end else begin
                state   <= PTR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
              end
            end
          end

          PTR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              pointer_o <= shift[1:0];
              state     <= PTR_ACK;
              sda_oe    <= 1'b1;
              bit_cnt   <= 4'd0;
            end
          end

          PTR_ACK: begin
            if (scl_fall) begin
              state   <= WDATA;
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
`ifdef LM75A_WRITE_EN
              wr_idx  <= 1'b0;
`endif
            end
          end

          WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state   <= WDATA_ACK;
              bit_cnt <= 4'd0;
`ifdef LM75A_WRITE_EN
              // Temp is read-only: NACK and discard.
              if (pointer_o != 2'd0) begin
                sda_oe <= 1'b1;
                wr_idx <= ~wr_idx;
                case (pointer_o)
                  2'd1: conf <= shift;
                  2'd2: begin
                    if (!wr_idx) thyst[15:8] <= shift;
                    else         thyst[7:0]  <= {shift[7], 7'b0000000};
                  end
                  default: begin
                    if (!wr_idx) tos[15:8] <= shift;
                    else         tos[7:0]  <= {shift[7], 7'b0000000};
                  end
                endcase
              end else begin
                sda_oe <= 1'b0;
              end
`else
              sda_oe <= 1'b0;
`endif
            end
          end

          WDATA_ACK: begin
            if (scl_fall) begin
              state   <= WDATA;
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
            end
          end

          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= RDATA_ACK;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
              end else begin
                sda_oe  <= ~tx[6];
                tx      <= {tx[5:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                rd_done <= 1'b1;
                state   <= IDLE;
              end else begin
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              // Alternate MSB/LSB; Conf reads the same byte either way.
              byte_idx <= ~byte_idx;
              state    <= RDATA;
              bit_cnt  <= 4'd1;
              if (byte_idx) begin
                tx     <= reg16[14:8];
                sda_oe <= ~reg16[15];
              end else begin
                tx     <= reg16[6:0];
                sda_oe <= ~reg16[7];
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/lm75a_i2c_slave.md
# lm75a_i2c_slave

Synthesizable I2C responder emulating the LM75A temperature sensor register map, used as the far end of the I2C master read/write controller in closed-loop simulation and on-FPGA loopback. It oversamples SCL/SDA on the system clock, detects START/STOP, matches the 7-bit device address, ACKs, accepts a pointer byte, and serves 16-bit Temp/Thyst/Tos and 8-bit Conf registers MSB-first. SDA is driven open-drain (low or released).

## Interface
- ADDR_HI, 4'b1001, fixed upper four address bits
- THYST_RST, 16'h4B00, Thyst reset value (75 °C)
- TOS_RST, 16'h5000, Tos reset value (80 °C)
- clk  input  1  system clock; must be ≥ 16× SCL frequency
- rst  input  1  asynchronous, active-low reset (0 = reset)
- scl  input  1  I2C clock from master (slave never stretches)
- sda  inout  1  I2C data; driven 0 when slave pulls low, else 1'bz
- i_address  input  3  A2..A0 address strap
- temp_in  input  11  live temperature, two's complement, 0.125 °C/LSB
- busy  output  1  high between an addressed START and the following STOP/START
- rd_done  output  1  one-clk pulse when master NACKs a read byte
- pointer_o  output  2  current pointer register

## Operation
- Input sync: scl, sda through 2-flop synchronizers; edge detect on synchronized copies.
- START: sda falls while scl high. STOP: sda rises while scl high. Either, in any state, returns FSM to ADDR (START) or IDLE (STOP), releases sda, bit counter cleared. Pointer and registers retained.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR: shift 8 bits on scl rising edges. If [7:1] == {ADDR_HI, i_address}: go ADDR_ACK; else IDLE (sda released, no ACK).
- ADDR_ACK: pull sda low for ACK clock. R/W=0 → PTR. R/W=1 → latch temp shadow = {temp_in, 5'b0}, byte index = 0, → RDATA.
- PTR: receive 8 bits; pointer_o ← byte[1:0] (bits [7:2] ignored); ACK → WDATA.
- WDATA: see Configuration.
- RDATA: drive selected byte MSB-first; sda bit changes only after synchronized scl falling edge. Sources: ptr 0 Temp shadow, 1 Conf, 2 Thyst, 3 Tos. 16-bit registers: MSB then LSB, further bytes wrap MSB, LSB… Conf: same byte repeated.
- RDATA_ACK: release sda; sample master bit on scl rise. ACK(0) → next byte. NACK(1) → rd_done pulse, IDLE-wait for STOP/START.
- Reset values: sda released, busy 0, rd_done 0, pointer_o 2'b00, Conf 8'h00, Thyst THYST_RST, Tos TOS_RST, temp shadow 16'h0000, FSM IDLE.
- Reset mid-transfer: immediate release of sda; master sees NACK/1s.

## Timing
- Sampling: bit captured on the clk after synchronized scl rising edge (3 clk after pin edge).
- Drive: slave updates sda 3 clk after pin scl falling edge; stable before next rising edge given clk ≥ 16× SCL.
- ACK window: sda low from falling edge ending bit 8 to falling edge ending ACK clock, then released (or next read bit driven).
- Temp shadow latched once per read transaction; temp_in changes mid-read do not tear MSB/LSB.
- Simultaneous START detect and scl edge in same clk: START wins.

## Configuration
- LM75A_WRITE_EN defined: WDATA accepts data bytes into pointed register (Conf: 1 byte; Thyst/Tos: MSB then LSB, low 7 bits of LSB forced 0); each ACKed; extra bytes wrap. Pointer 0 (Temp) writes NACKed and discarded.
- Undefined: registers read-only at reset values; every byte after the pointer byte NACKed.

## Test plan
- i_address=3'b000, temp_in=11'h0C8; write 0x90, ptr 0x00, restart 0x91, read 2 bytes (ACK, NACK) -> ACKs at bit 9 of 0x90/0x00/0x91, data 0x19 0x00, rd_done pulse.
- Address 0x92 with i_address=3'b000 -> no ACK, sda never driven, busy stays 0.
- Pointer 0x03 then read 4 bytes -> 0x50 0x00 0x50 0x00 (wrap).
- LM75A_WRITE_EN: write 0x90, 0x02, 0x46, 0xFF, then read ptr 2 -> 0x46 0x80; without macro -> 0x46 byte NACKed, read returns 0x4B 0x00.
- temp_in changed from 11'h0C8 to 11'h7FF between MSB and LSB -> LSB still 0x00.
- rst asserted during RDATA while slave drives 0 -> sda released same cycle, pointer_o 0, next transaction works normally.
